// File: rtl/arm_fk_if.sv
// arm_fk_if: request, result and external CORDIC signals of the two-link FK sequencer.
interface arm_fk_if #(
    parameter int ANG_W = 18,
    parameter int LEN_W = 18,
    parameter int OUT_W = 19
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ANG_W-1:0] t1;
    logic signed [ANG_W-1:0] t2;
    logic        [LEN_W-1:0] len1;
    logic        [LEN_W-1:0] len2;
    logic signed [ANG_W-1:0] cordic_theta;
    logic signed [ANG_W-1:0] cordic_sin;
    logic signed [ANG_W-1:0] cordic_cos;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] x_pos;
    logic signed [OUT_W-1:0] y_pos;

    modport master (
        output in_valid, t1, t2, len1, len2, cordic_sin, cordic_cos, out_ready,
        input  in_ready, cordic_theta, out_valid, x_pos, y_pos
    );
    modport slave (
        input  in_valid, t1, t2, len1, len2, cordic_sin, cordic_cos, out_ready,
        output in_ready, cordic_theta, out_valid, x_pos, y_pos
    );
endinterface

// File: rtl/arm_fk_sequencer.sv
// arm_fk_sequencer: two-link planar forward kinematics time-sharing one external CORDIC.
module arm_fk_sequencer #(
    parameter int ANG_W      = 18,
    parameter int LEN_W      = 18,
    parameter int OUT_W      = 19,
    parameter int CORDIC_LAT = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    arm_fk_if.slave   bus
);
    localparam int PW = LEN_W + ANG_W + 1;
    localparam int AW = OUT_W + 2;
    localparam logic signed [ANG_W:0] D90  = (ANG_W + 1)'(90 * 128);
    localparam logic signed [ANG_W:0] D180 = (ANG_W + 1)'(180 * 128);
    localparam logic signed [ANG_W:0] D360 = (ANG_W + 1)'(360 * 128);
    localparam logic signed [PW-1:0]  HALF = PW'(64);
    localparam logic signed [AW-1:0]  SMAX = AW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [AW-1:0]  SMIN = -AW'(2 ** (OUT_W - 1));
    localparam logic [7:0]            LAST = 8'(CORDIC_LAT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, MAC, DONE} state_e;
    state_e state_q, state_d;

    logic signed [ANG_W-1:0] t1_q, t2_q, theta_q, sin_q, cos_q;
    logic        [LEN_W-1:0] len1_q, len2_q;
    logic                    phase_q, neg_q;
    logic        [7:0]       cnt_q;
    logic signed [AW-1:0]    x_acc_q, y_acc_q;
    logic signed [OUT_W-1:0] x_q, y_q;

    logic signed [ANG_W:0]   phi, phi_w, phi_r;
    logic                    neg_d;
    logic signed [LEN_W:0]   len_s;
    logic signed [PW-1:0]    pc, ps, xr, yr;
    logic signed [AW-1:0]    x_sum, y_sum;

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [AW-1:0] v);
        return v > SMAX ? SMAX[OUT_W-1:0] : v < SMIN ? SMIN[OUT_W-1:0] : v[OUT_W-1:0];
    endfunction

    // Wrap into [-180,180), then fold into [-90,90] and remember the sign flip.
    always_comb begin
        phi   = phase_q ? (ANG_W + 1)'(t1_q) + (ANG_W + 1)'(t2_q) : (ANG_W + 1)'(t1_q);
        phi_w = phi >= D180 ? phi - D360 : phi < -D180 ? phi + D360 : phi;
        neg_d = phi_w > D90 || phi_w < -D90;
        phi_r = phi_w > D90 ? phi_w - D180 : phi_w < -D90 ? phi_w + D180 : phi_w;
        len_s = {1'b0, phase_q ? len2_q : len1_q};
        pc    = PW'(len_s) * PW'(cos_q);
        ps    = PW'(len_s) * PW'(sin_q);
        xr    = (pc + HALF) >>> 7;
        yr    = (ps + HALF) >>> 7;
        x_sum = x_acc_q + xr[AW-1:0];
        y_sum = y_acc_q + yr[AW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.in_valid ? REQ : IDLE;
            REQ:     state_d = WAIT;
            WAIT:    state_d = cnt_q == LAST ? MAC : WAIT;
            MAC:     state_d = phase_q ? DONE : REQ;
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready     = state_q == IDLE;
        bus.out_valid    = state_q == DONE;
        bus.cordic_theta = theta_q;
        bus.x_pos        = x_q;
        bus.y_pos        = y_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            {t1_q, t2_q, theta_q, sin_q, cos_q} <= '0;
            {len1_q, len2_q, phase_q, neg_q, cnt_q} <= '0;
            {x_acc_q, y_acc_q, x_q, y_q} <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    t1_q    <= bus.t1;
                    t2_q    <= bus.t2;
                    len1_q  <= bus.len1;
                    len2_q  <= bus.len2;
                    x_acc_q <= '0;
                    y_acc_q <= '0;
                    phase_q <= 1'b0;
                end
                REQ: begin
                    theta_q <= phi_r[ANG_W-1:0];
                    neg_q   <= neg_d;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == LAST) begin
                        sin_q <= neg_q ? -bus.cordic_sin : bus.cordic_sin;
                        cos_q <= neg_q ? -bus.cordic_cos : bus.cordic_cos;
                    end
                end
                MAC: begin
                    x_acc_q <= x_sum;
                    y_acc_q <= y_sum;
                    phase_q <= 1'b1;
                    if (phase_q) begin
                        x_q <= sat(x_sum);
                        y_q <= sat(y_sum);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_arm_fk_sequencer.sv
// tb_arm_fk_sequencer: directed vectors against a small table-driven CORDIC model.
module tb_arm_fk_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    arm_fk_if bus();

    arm_fk_sequencer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // One register stage: theta updated at edge E is sampled by the DUT at E+2.
    always @(posedge clk) begin
        case (bus.cordic_theta)
            18'sd0:     begin bus.cordic_sin <= 18'sd0;   bus.cordic_cos <= 18'sd128; end
            18'sd11520: begin bus.cordic_sin <= 18'sd128; bus.cordic_cos <= 18'sd0;   end
            18'sd1280:  begin bus.cordic_sin <= 18'sd22;  bus.cordic_cos <= 18'sd126; end
            -18'sd2560: begin bus.cordic_sin <= -18'sd44; bus.cordic_cos <= 18'sd120; end
            default:    begin bus.cordic_sin <= 18'sd0;   bus.cordic_cos <= 18'sd0;   end
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run(input int a1, input int a2, input int l1, input int l2, input bit poke,
                       output int lat, output int th0, output int th1, output int rdy);
        @(negedge clk);
        bus.t1       = 18'(a1);
        bus.t2       = 18'(a2);
        bus.len1     = 18'(l1);
        bus.len2     = 18'(l2);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        th0 = 0;
        th1 = 0;
        rdy = 0;
        while (!bus.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 1) th0 = int'(bus.cordic_theta);
            if (lat == 2) rdy = int'(bus.in_ready);
            if (lat == 5) th1 = int'(bus.cordic_theta);
            bus.in_valid = poke && lat == 3;
            if (poke && lat == 3) bus.t1 = 18'sd11520;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic take(output int x, output int y);
        x = int'(bus.x_pos);
        y = int'(bus.y_pos);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("drop_valid", int'(bus.out_valid), 0);
    endtask

    int lat, th0, th1, rdy, x, y;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.t1 = '0; bus.t2 = '0; bus.len1 = '0; bus.len2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_x", int'(bus.x_pos), 0);
        chk("rst_theta", int'(bus.cordic_theta), 0);
        rst_n = 1'b1;

        run(0, 0, 1280, 1280, 1'b0, lat, th0, th1, rdy);
        chk("t1_lat", lat, 8);
        chk("t1_busy_ready", rdy, 0);
        take(x, y);
        chk("t1_x", x, 2560);
        chk("t1_y", y, 0);

        run(11520, 0, 1280, 1280, 1'b0, lat, th0, th1, rdy);
        chk("t2_th0", th0, 11520);
        chk("t2_th1", th1, 11520);
        take(x, y);
        chk("t2_x", x, 0);
        chk("t2_y", y, 2560);

        run(11520, 11520, 1280, 1280, 1'b0, lat, th0, th1, rdy);
        chk("t3_th1", th1, 0);
        take(x, y);
        chk("t3_x", x, -1280);
        chk("t3_y", y, 1280);

        // -170 folds to 10 (neg); -200 wraps to 160, folds to -20 (neg); table-quantised sums.
        run(-21760, -3840, 1280, 1280, 1'b0, lat, th0, th1, rdy);
        chk("t4_th0", th0, 1280);
        chk("t4_th1", th1, -2560);
        take(x, y);
        chk("t4_x", x, -2460);
        chk("t4_y", y, 220);

        run(0, 0, 192000, 192000, 1'b0, lat, th0, th1, rdy);
        repeat (5) @(negedge clk);
        chk("t5_hold_valid", int'(bus.out_valid), 1);
        chk("t5_hold_ready", int'(bus.in_ready), 0);
        take(x, y);
        chk("t5_x_sat", x, 262143);
        chk("t5_y", y, 0);

        @(negedge clk);
        bus.t1 = '0; bus.t2 = '0; bus.len1 = 18'd1280; bus.len2 = 18'd1280;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_ready", int'(bus.in_ready), 1);
        chk("t6_rst_valid", int'(bus.out_valid), 0);
        chk("t6_rst_x", int'(bus.x_pos), 0);
        chk("t6_rst_y", int'(bus.y_pos), 0);

        run(0, 0, 1280, 1280, 1'b1, lat, th0, th1, rdy);
        chk("t6_lat", lat, 8);
        repeat (2) @(negedge clk);
        chk("t6_still_valid", int'(bus.out_valid), 1);
        take(x, y);
        chk("t6_x", x, 2560);
        chk("t6_y", y, 0);
        @(negedge clk);
        chk("t6_idle_ready", int'(bus.in_ready), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
